pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 22 ++
 rtl/npc_calc.sv | 39 +++
 rtl/pc_unit.sv | 106 ++++++++++
 tb/tb_pc_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the PC unit.
//   pc_op_e    - next-PC select (SEQ, BR, J, JR)
//   pc_state_e - fetch FSM states (BOOT, REQ, HOLD)
//   PC_RESET_DEFAULT - default PC after reset
package pc_pkg;

    typedef enum logic [1:0] {
        PC_OP_SEQ = 2'b00,
        PC_OP_BR  = 2'b01,
        PC_OP_J   = 2'b10,
        PC_OP_JR  = 2'b11
    } pc_op_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } pc_state_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC arithmetic.
//   pc       - current PC
//   pc_op    - next-PC select (pc_op_e encoding)
//   imm16    - signed branch offset in words
//   target26 - j/jal instruction index
//   rs_data  - jr target (low two bits dropped so PC stays word aligned)
//   pc_plus4 - pc + 4 (link value)
//   npc      - selected next PC
// All arithmetic is modulo 2^32; wrap-around is silent.
module npc_calc
    import pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_op,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc
);

    logic [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    // word offset sign-extended and scaled to bytes
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = pc_plus4;
        case (pc_op)
            PC_OP_SEQ: npc = pc_plus4;
            PC_OP_BR:  npc = pc_plus4 + br_off;
            PC_OP_J:   npc = {pc_plus4[31:28], target26, 2'b00};
            PC_OP_JR:  npc = rs_data & ~32'd3;
            default:   npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter, fetch handshake FSM and retired-instruction counter.
//   clk, rst_n  - clock, asynchronous active-low reset
//   pc_op       - next-PC select (00 seq, 01 branch, 10 j/jal, 11 jr)
//   imm16       - signed branch word offset
//   target26    - j/jal index
//   rs_data     - jr target
//   stall       - hold PC; wins over if_ack
//   if_ack      - instruction word returned for if_addr
//   if_req      - fetch request (registered, high in REQ)
//   if_addr, pc - current PC
//   pc_plus4    - pc + 4
//   retired     - committed PC update count (wraps silently)
//   addr_err    - misaligned jr target flag
// Optional feature: define PC_ALIGN_CHECK_EN to block misaligned jr commits
// and raise addr_err on the blocked cycle; otherwise jr low bits are
// cleared and addr_err is tied low.
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pc_op,
    input  logic [15:0]      imm16,
    input  logic [25:0]      target26,
    input  logic [31:0]      rs_data,
    input  logic             stall,
    input  logic             if_ack,
    output logic             if_req,
    output logic [31:0]      if_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired,
    output logic             addr_err
);

    pc_state_e   state;
    logic [31:0] npc;
    logic        attempt;
    logic        blocked;
    logic        commit;

    npc_calc u_npc (
        .pc       (pc),
        .pc_op    (pc_op),
        .imm16    (imm16),
        .target26 (target26),
        .rs_data  (rs_data),
        .pc_plus4 (pc_plus4),
        .npc      (npc)
    );

    // A commit is attempted on an acked fetch in REQ, or on leaving HOLD.
    assign attempt = !stall && ((state == ST_REQ && if_ack) || state == ST_HOLD);

`ifdef PC_ALIGN_CHECK_EN
    assign blocked  = (pc_op == PC_OP_JR) && (rs_data[1:0] != 2'b00);
    assign addr_err = attempt && blocked;
`else
    assign blocked  = 1'b0;
    assign addr_err = 1'b0;
`endif

    assign commit  = attempt && !blocked;
    assign if_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_BOOT;
            if_req  <= 1'b0;
            pc      <= RESET_PC;
            retired <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state  <= ST_REQ;
                    if_req <= 1'b1;
                end
                ST_REQ: begin
                    // word arrived but pipeline is stalled: park in HOLD
                    if (if_ack && stall) begin
                        state  <= ST_HOLD;
                        if_req <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state  <= ST_REQ;
                        if_req <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_BOOT;
                    if_req <= 1'b0;
                end
            endcase
            if (commit) begin
                pc      <= npc;
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
    import pc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_op;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_data;
    logic        stall;
    logic        if_ack;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;
    logic        addr_err;

    int n_run;
    int n_fail;
    logic [31:0] exp_ret;

    pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_op    (pc_op),
        .imm16    (imm16),
        .target26 (target26),
        .rs_data  (rs_data),
        .stall    (stall),
        .if_ack   (if_ack),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .retired  (retired),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one committing step: set controls, advance, check pc and counter
    task automatic commit_step(input string tag, input logic [1:0] op,
                               input logic [31:0] rs, input logic [31:0] exp_pc);
        pc_op   = op;
        rs_data = rs;
        tick();
        exp_ret = exp_ret + 32'd1;
        chk(tag, pc, exp_pc);
        chk({tag, "_ret"}, retired, exp_ret);
    endtask

    initial begin
        n_run    = 0;
        n_fail   = 0;
        exp_ret  = 32'd0;
        rst_n    = 1'b0;
        pc_op    = 2'b00;
        imm16    = 16'h0;
        target26 = 26'h0;
        rs_data  = 32'h0;
        stall    = 1'b0;
        if_ack   = 1'b1;

        // reset state, with if_ack ignored while in reset
        tick(); tick();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_ret", retired, 32'd0);
        chk("rst_req", 32'(if_req), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_addr", if_addr, 32'h0000_3000);

        // release: BOOT cycle, then fetch at RESET_PC
        rst_n = 1'b1;
        chk("boot_req", 32'(if_req), 32'd0);
        tick();
        chk("req_pc", pc, 32'h0000_3000);
        chk("req_req", 32'(if_req), 32'd1);
        chk("req_ret", retired, 32'd0);
        commit_step("seq1", 2'b00, 32'h0, 32'h0000_3004);
        commit_step("seq2", 2'b00, 32'h0, 32'h0000_3008);
        chk("plus4", pc_plus4, 32'h0000_300C);

        // branches from 3008
        imm16 = 16'hFFFE;
        commit_step("br_neg", 2'b01, 32'h0, 32'h0000_3004);
        commit_step("seq3", 2'b00, 32'h0, 32'h0000_3008);
        imm16 = 16'h0003;
        commit_step("br_pos", 2'b01, 32'h0, 32'h0000_3018);

        // j/jal keeps pc_plus4 upper nibble
        commit_step("jr_to3", 2'b11, 32'h3000_0010, 32'h3000_0010);
        target26 = 26'h0000100;
        commit_step("j", 2'b10, 32'h0, 32'h3000_0400);

        // silent wrap at top of address space
        commit_step("jr_top", 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        commit_step("wrap", 2'b00, 32'h0, 32'h0000_0000);

        // stall with if_ack at 3010
        commit_step("jr3010", 2'b11, 32'h0000_3010, 32'h0000_3010);
        pc_op = 2'b00;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'h0000_3010);
            chk("stall_req", 32'(if_req), 32'd0);
            chk("stall_ret", retired, exp_ret);
        end
        stall = 1'b0;
        tick();
        exp_ret = exp_ret + 32'd1;
        chk("unstall_pc", pc, 32'h0000_3014);
        chk("unstall_req", 32'(if_req), 32'd1);
        chk("unstall_ret", retired, exp_ret);

        // no ack holds everything
        if_ack = 1'b0;
        tick();
        chk("noack_pc", pc, 32'h0000_3014);
        chk("noack_ret", retired, exp_ret);
        if_ack = 1'b1;

        // misaligned jr
        pc_op   = 2'b11;
        rs_data = 32'h0000_3021;
        #1;
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_err", 32'(addr_err), 32'd1);
        tick();
        chk("mis_pc", pc, 32'h0000_3014);
        chk("mis_ret", retired, exp_ret);
        pc_op = 2'b00;
        #1;
        chk("mis_err_clr", 32'(addr_err), 32'd0);
`else
        chk("mis_err", 32'(addr_err), 32'd0);
        tick();
        exp_ret = exp_ret + 32'd1;
        chk("mis_pc", pc, 32'h0000_3020);
        chk("mis_ret", retired, exp_ret);
`endif

        // mid-operation reset while in HOLD at 3040
        commit_step("jr3040", 2'b11, 32'h0000_3040, 32'h0000_3040);
        pc_op = 2'b00;
        stall = 1'b1;
        tick();
        chk("hold_pc", pc, 32'h0000_3040);
        chk("hold_req", 32'(if_req), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_pc", pc, 32'h0000_3000);
        chk("mrst_ret", retired, 32'd0);
        chk("mrst_req", 32'(if_req), 32'd0);
        stall = 1'b0;
        tick();
        chk("mrst_hold_pc", pc, 32'h0000_3000);
        rst_n   = 1'b1;
        exp_ret = 32'd0;
        tick();
        chk("restart_pc", pc, 32'h0000_3000);
        chk("restart_req", 32'(if_req), 32'd1);
        commit_step("restart_seq", 2'b00, 32'h0, 32'h0000_3004);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
